// File: rtl/alarm_time_pkg.sv
// Shared definitions for the 24-hour clock: BCD limits, blank digit code
// and the alarm ring state encoding.
package alarm_time_pkg;

    localparam logic [7:0] MIN_MAX     = 8'h59;
    localparam logic [5:0] HOUR_MAX    = 6'h23;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } ring_state_e;

endpackage

// File: rtl/alarm_time_if.sv
// Command interface from the adjust-mode controller (master) to the
// alarm-time register block (slave): clear/increment strobes and blink enables.
interface alarm_time_if;
    logic MINCLR1;
    logic HOURCLR1;
    logic MININC1;
    logic HOURINC1;
    logic MINON1;
    logic HOURON1;

    modport master (
        output MINCLR1, HOURCLR1, MININC1, HOURINC1, MINON1, HOURON1
    );

    modport slave (
        input MINCLR1, HOURCLR1, MININC1, HOURINC1, MINON1, HOURON1
    );
endinterface

// File: rtl/bcd_wrap_cnt.sv
// Two-digit BCD counter that wraps from MAX to zero; clear has priority
// over increment. The tens digit occupies bits [W-1:4].
module bcd_wrap_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam int           TW       = W - 4;
    localparam logic [TW-1:0] TENS_ONE = TW'(1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == MAX) begin
                cnt_d = '0;
            end else if (cnt_q[3:0] == 4'd9) begin
                cnt_d = {cnt_q[W-1:4] + TENS_ONE, 4'd0};
            end else begin
                cnt_d = {cnt_q[W-1:4], cnt_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alarm_time.sv
// Alarm minute/hour registers, blink-masked display digits, once-per-second
// alarm comparison and the timed ring state machine gating the buzzer.
module alarm_time
    import alarm_time_pkg::*;
#(
    parameter int RING_SEC = 60
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN1HZ,
    input  logic               SIG2HZ,
    alarm_time_if.slave        adj,
    input  logic               ALMEN,
    input  logic               STOP,
    input  logic [7:0]         CURSEC,
    input  logic [7:0]         CURMIN,
    input  logic [5:0]         CURHOUR,
    output logic [7:0]         AMIN,
    output logic [5:0]         AHOUR,
    output logic [7:0]         DMIN,
    output logic [5:0]         DHOUR,
    output logic               RING,
    output logic               BUZZ
);

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

    ring_state_e state_d, state_q;
    logic [7:0]  cnt_d, cnt_q;
    logic        match;

    bcd_wrap_cnt #(.W(8), .MAX(MIN_MAX)) u_min_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (adj.MINCLR1),
        .inc (adj.MININC1),
        .cnt (AMIN)
    );

    bcd_wrap_cnt #(.W(6), .MAX(HOUR_MAX)) u_hour_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (adj.HOURCLR1),
        .inc (adj.HOURINC1),
        .cnt (AHOUR)
    );

    // Compared against the alarm value held before the edge, so a same-cycle
    // increment cannot cancel a match.
    assign match = ALMEN & EN1HZ & (CURSEC == 8'h00) &
                   (CURMIN == AMIN) & (CURHOUR == AHOUR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (match && !STOP) begin
                    state_d = RINGING;
                    cnt_d   = 8'd0;
                end
            end
            RINGING: begin
                if (STOP || !ALMEN) begin
                    state_d = IDLE;
                end else if (EN1HZ) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == RING_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RING  = (state_q == RINGING);
    assign BUZZ  = RING & SIG2HZ;
    assign DMIN  = adj.MINON1  ? AMIN  : {BLANK_DIGIT, BLANK_DIGIT};
    assign DHOUR = adj.HOURON1 ? AHOUR : {BLANK_DIGIT[1:0], BLANK_DIGIT};

endmodule

// File: tb/tb_alarm_time.sv
// Directed self-checking bench for alarm_time: register stepping, blink
// masking, ring duration, stop/disarm, and asynchronous reset.
module tb_alarm_time;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN1HZ;
    logic       SIG2HZ = 1'b0;
    logic       ALMEN;
    logic       STOP;
    logic [7:0] CURSEC;
    logic [7:0] CURMIN;
    logic [5:0] CURHOUR;
    logic [7:0] AMIN;
    logic [5:0] AHOUR;
    logic [7:0] DMIN;
    logic [5:0] DHOUR;
    logic       RING;
    logic       BUZZ;

    int checks   = 0;
    int failures = 0;
    int exp_min  = 0;
    int exp_hour = 0;

    alarm_time_if adj_if ();

    alarm_time #(.RING_SEC(60)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN1HZ   (EN1HZ),
        .SIG2HZ  (SIG2HZ),
        .adj     (adj_if.slave),
        .ALMEN   (ALMEN),
        .STOP    (STOP),
        .CURSEC  (CURSEC),
        .CURMIN  (CURMIN),
        .CURHOUR (CURHOUR),
        .AMIN    (AMIN),
        .AHOUR   (AHOUR),
        .DMIN    (DMIN),
        .DHOUR   (DHOUR),
        .RING    (RING),
        .BUZZ    (BUZZ)
    );

    always #5 CLK = ~CLK;
    always #40 SIG2HZ = ~SIG2HZ;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ring(input string tag, input logic exp_ring);
        check_output({tag, "_ring"}, RING, exp_ring);
        check_output({tag, "_buzz"}, BUZZ, exp_ring & SIG2HZ);
    endtask

    task automatic pulse_min_inc();
        adj_if.MININC1 = 1'b1;
        tick();
        adj_if.MININC1 = 1'b0;
        exp_min = (exp_min + 1) % 60;
    endtask

    task automatic pulse_hour_inc();
        adj_if.HOURINC1 = 1'b1;
        tick();
        adj_if.HOURINC1 = 1'b0;
        exp_hour = (exp_hour + 1) % 24;
    endtask

    task automatic pulse_en1hz();
        EN1HZ = 1'b1;
        tick();
        EN1HZ = 1'b0;
    endtask

    // Drive the current time to the alarm setting on a second boundary.
    task automatic start_ring();
        CURSEC  = 8'h00;
        CURMIN  = to_bcd(exp_min);
        CURHOUR = 6'(to_bcd(exp_hour));
        pulse_en1hz();
        CURSEC  = 8'h01;
    endtask

    initial begin
        RST = 1'b1;
        EN1HZ = 1'b0;
        ALMEN = 1'b0;
        STOP = 1'b0;
        CURSEC = 8'h01;
        CURMIN = 8'h00;
        CURHOUR = 6'h00;
        adj_if.MINCLR1 = 1'b0;
        adj_if.HOURCLR1 = 1'b0;
        adj_if.MININC1 = 1'b0;
        adj_if.HOURINC1 = 1'b0;
        adj_if.MINON1 = 1'b1;
        adj_if.HOURON1 = 1'b1;
        #12;
        check_output("rst_amin", AMIN, 8'h00);
        check_output("rst_ahour", AHOUR, 6'h00);
        check_output("rst_dmin", DMIN, 8'h00);
        check_output("rst_dhour", DHOUR, 6'h00);
        check_ring("rst", 1'b0);
        RST = 1'b0;
        tick();

        // Full minute sweep 00..59 and wrap to 00, no carry into hours.
        for (int i = 0; i < 60; i++) begin
            pulse_min_inc();
            check_output("min_step", AMIN, to_bcd(exp_min));
        end
        check_output("min_wrap", AMIN, 8'h00);
        check_output("min_nocarry", AHOUR, 6'h00);

        for (int i = 0; i < 24; i++) begin
            pulse_hour_inc();
            check_output("hour_step", AHOUR, 6'(to_bcd(exp_hour)));
        end
        check_output("hour_wrap", AHOUR, 6'h00);

        for (int i = 0; i < 5; i++) pulse_hour_inc();
        for (int i = 0; i < 7; i++) pulse_min_inc();
        check_output("pre_clr_hour", AHOUR, 6'h05);
        adj_if.HOURCLR1 = 1'b1;
        adj_if.HOURINC1 = 1'b1;
        adj_if.MININC1 = 1'b1;
        tick();
        adj_if.HOURCLR1 = 1'b0;
        adj_if.HOURINC1 = 1'b0;
        adj_if.MININC1 = 1'b0;
        exp_hour = 0;
        exp_min = 8;
        check_output("hour_clr_beats_inc", AHOUR, 6'h00);
        check_output("min_indep_inc", AMIN, 8'h08);
        adj_if.MINCLR1 = 1'b1;
        adj_if.MININC1 = 1'b1;
        tick();
        adj_if.MINCLR1 = 1'b0;
        adj_if.MININC1 = 1'b0;
        exp_min = 0;
        check_output("min_clr_beats_inc", AMIN, 8'h00);

        for (int i = 0; i < 30; i++) pulse_min_inc();
        for (int i = 0; i < 7; i++) pulse_hour_inc();
        check_output("set_amin30", AMIN, 8'h30);
        check_output("set_ahour07", AHOUR, 6'h07);
        adj_if.MINON1 = 1'b0;
        #1;
        check_output("blank_dmin", DMIN, 8'hFF);
        check_output("blank_amin_kept", AMIN, 8'h30);
        check_output("blank_dhour_on", DHOUR, 6'h07);
        adj_if.MINON1 = 1'b1;
        adj_if.HOURON1 = 1'b0;
        #1;
        check_output("blank_dhour", DHOUR, 6'h3F);
        check_output("unblank_dmin", DMIN, 8'h30);
        adj_if.HOURON1 = 1'b1;
        #1;
        check_output("unblank_dhour", DHOUR, 6'h07);

        // 07:30:00 match with a same-cycle minute increment; ring for 60 s,
        // with a second match at pulse 10 that must not restart the count.
        ALMEN = 1'b1;
        CURSEC = 8'h00;
        CURMIN = 8'h30;
        CURHOUR = 6'h07;
        EN1HZ = 1'b1;
        adj_if.MININC1 = 1'b1;
        tick();
        EN1HZ = 1'b0;
        adj_if.MININC1 = 1'b0;
        exp_min = 31;
        CURSEC = 8'h01;
        check_ring("ring_start", 1'b1);
        check_output("ring_inc_amin", AMIN, 8'h31);
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin
                CURSEC = 8'h00;
                CURMIN = 8'h31;
            end
            pulse_en1hz();
            CURSEC = 8'h01;
            check_ring("ring_hold", k < 60);
            tick();
            check_ring("ring_gap", k < 60);
        end
        tick();
        check_ring("ring_done", 1'b0);

        start_ring();
        check_ring("stop_start", 1'b1);
        pulse_en1hz();
        pulse_en1hz();
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check_ring("stop_drop", 1'b0);

        start_ring();
        check_ring("disarm_start", 1'b1);
        ALMEN = 1'b0;
        tick();
        check_ring("disarm_drop", 1'b0);

        start_ring();
        check_ring("match_disarmed", 1'b0);
        ALMEN = 1'b1;

        STOP = 1'b1;
        start_ring();
        STOP = 1'b0;
        check_ring("stop_with_match", 1'b0);

        // Reset applied between clock edges must drop the ring at once.
        start_ring();
        check_ring("reset_start", 1'b1);
        #3;
        RST = 1'b1;
        #1;
        check_output("async_rst_ring", RING, 1'b0);
        check_output("async_rst_buzz", BUZZ, 1'b0);
        check_output("async_rst_amin", AMIN, 8'h00);
        check_output("async_rst_ahour", AHOUR, 6'h00);
        tick();
        RST = 1'b0;
        tick();
        check_ring("post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_time.md
# alarm_time

Alarm-time register and ring controller for the 24-hour clock. It is the consumer end of the adjust-mode controller's command interface. It takes that controller's clear, increment and blink-enable strobes and applies them to BCD alarm-minute and alarm-hour registers. It drives blink-masked display digits, compares the alarm against the running time once per second, and runs a timed ring state machine that gates the buzzer.

## Interface
Parameters:
- RING_SEC, default 60: number of EN1HZ pulses the alarm rings before self-stopping; legal range 1–255.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- EN1HZ  in  1  one-CLK-cycle pulse, once per second.
- SIG2HZ  in  1  2 Hz square wave, used for buzzer modulation.
- MINCLR1, HOURCLR1  in  1  clear alarm minute / hour; one-cycle strobes.
- MININC1, HOURINC1  in  1  increment alarm minute / hour; one-cycle strobes.
- MINON1, HOURON1  in  1  display enable per field; 0 blanks that field.
- ALMEN  in  1  alarm armed (level).
- STOP  in  1  stop ringing (one-cycle strobe).
- CURSEC  in  8  current seconds, BCD 00–59.
- CURMIN  in  8  current minutes, BCD 00–59.
- CURHOUR  in  6  current hours, BCD {tens[1:0], ones[3:0]}, 00–23.
- AMIN  out  8  alarm minute register, BCD.
- AHOUR  out  6  alarm hour register, BCD.
- DMIN  out  8  display minute; AMIN when MINON1=1, else 8'hFF.
- DHOUR  out  6  display hour; AHOUR when HOURON1=1, else 6'h3F.
- RING  out  1  high while the alarm is ringing.
- BUZZ  out  1  RING & SIG2HZ.

## Operation
- Minute register:
  - MINCLR1 sets AMIN to 00.
  - Else MININC1 does a BCD +1: x9 goes to (x+1)0, and 59 wraps to 00.
  - No carry into the hour register.
- Hour register:
  - HOURCLR1 sets AHOUR to 00.
  - Else HOURINC1 does a BCD +1: 09→10, 19→20, 23→00.
- CLR beats INC when both are asserted in the same cycle. The minute and hour fields update independently in the same cycle.
- DMIN, DHOUR and BUZZ are combinational from registers and inputs. Blank code is all-ones per digit.
- match = ALMEN & EN1HZ & (CURSEC==8'h00) & (CURMIN==AMIN) & (CURHOUR==AHOUR).
- FSM states IDLE and RINGING. An 8-bit counter CNT counts seconds of ringing.
  - IDLE → RINGING on match with STOP=0; CNT is set to 0.
  - In RINGING, each EN1HZ increments CNT. If CNT==RING_SEC-1 at that EN1HZ, the FSM goes to IDLE.
  - RINGING → IDLE immediately on STOP=1 or ALMEN=0. This has priority over the counter.
  - A match while RINGING is ignored and CNT is not restarted.
  - Adjust strobes do not affect the FSM.
- RING = (state==RINGING).

## Timing
- Reset values: AMIN=00, AHOUR=00, state IDLE, CNT=0, RING=0, BUZZ=0. DMIN and DHOUR follow the blink-mask rule applied to 00.
- Register updates take one cycle: a strobe sampled at edge n shows on AMIN/AHOUR after edge n.
- RING rises the cycle after the matching EN1HZ cycle. It stays high for exactly RING_SEC EN1HZ pulses, counted from the first EN1HZ after entry, then falls the cycle after the last one.
- STOP and the terminal EN1HZ in the same cycle give IDLE after one edge.
- STOP and a match in the same cycle while in IDLE leave the FSM in IDLE.
- The comparison uses AMIN/AHOUR as held before the edge. An increment in the same cycle as a match does not cancel that match.
- RST asserted mid-ring drops RING and BUZZ asynchronously.
- Out-of-range CURxx values never match; no checking is performed.

## Structure
- Shared clock package holds:
  - BCD limits: MIN_MAX=8'h59, HOUR_MAX=6'h23.
  - Blank digit code 4'hF.
  - FSM state encoding: IDLE=1'b0, RINGING=1'b1.
- One sub-module, bcd_wrap_cnt, parameterised by width and max BCD value, with clr/inc inputs and CLR priority. It is instantiated for the minute and hour fields and is reusable by the timekeeping counters.
- The FSM, ring counter, comparator and output masking stay in alarm_time.

## Test plan
- Reset, then 60× MININC1 → AMIN steps 00…59 and returns to 00; AHOUR stays 00.
- AHOUR=23, HOURINC1 → 00. AHOUR=09, HOURINC1 → 10. HOURCLR1 and HOURINC1 together → 00.
- MINON1=0 → DMIN=8'hFF while AMIN is unchanged. HOURON1=0 → DHOUR=6'h3F.
- AMIN=30, AHOUR=07, ALMEN=1, drive 07:30:00 with EN1HZ → RING=1 next cycle. It holds for 60 EN1HZ pulses, then drops to 0. BUZZ follows SIG2HZ throughout.
- Ring active, pulse STOP → RING=0 next cycle. Repeat with ALMEN dropping to 0 instead → same result.
- Match cycle with ALMEN=0 → no ring. RST asserted mid-ring → RING=0 immediately, AMIN=00.
